decode_stage_pipe: RTL

Parametrised decode stage and ID/EX pipeline register with a valid/ready handshake. It contains the architectural register file with write-through bypass, and detects load-use hazards, injecting bubbles for them. It accepts branch flushes and keeps a saturating bubble counter. It sits between the fetch-stage register and the execute stage. The control bundle and extended immediate arrive pre-decoded from Control_Unit_Top and Sign_Extend instances in the core top.

---
 rtl/decode_pkg.sv | 22 ++
 rtl/decode_stage_pipe_if.sv | 50 +++++
 rtl/decode_stage_pipe_regfile_bypass.sv | 45 ++++
 rtl/decode_stage_pipe.sv | 99 +++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types and constants for the decode stage: control bundle layout,
// the all-zero NOP bundle and instruction field positions.
package decode_pkg;

    localparam int ALUCTL_W = 3;

    typedef struct packed {
        logic                reg_write;
        logic                alu_src;
        logic                mem_write;
        logic                result_src;
        logic                branch;
        logic [ALUCTL_W-1:0] alu_control;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Decode-slot, writeback and execute-slot signals of the decode stage.
// The slave modport is the decode stage itself; master is its environment.
interface decode_stage_pipe_if #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    import decode_pkg::*;

    logic             valid_d;
    logic             ready_d;
    logic [31:0]      instr_d;
    logic [XLEN-1:0]  pc_d;
    logic [XLEN-1:0]  pc_plus4_d;
    ctrl_t            ctrl_d;
    logic [XLEN-1:0]  imm_ext_d;

    logic             reg_write_w;
    logic [AW-1:0]    rd_w;
    logic [XLEN-1:0]  result_w;

    logic             flush_e;
    logic             valid_e;
    logic             ready_e;
    ctrl_t            ctrl_e;
    logic [XLEN-1:0]  rd1_e;
    logic [XLEN-1:0]  rd2_e;
    logic [XLEN-1:0]  imm_ext_e;
    logic [XLEN-1:0]  pc_e;
    logic [XLEN-1:0]  pc_plus4_e;
    logic [AW-1:0]    rs1_e;
    logic [AW-1:0]    rs2_e;
    logic [AW-1:0]    rd_e;
    logic [CNT_W-1:0] bubble_cnt;

    modport slave (
        input  valid_d, instr_d, pc_d, pc_plus4_d, ctrl_d, imm_ext_d,
        input  reg_write_w, rd_w, result_w, flush_e, ready_e,
        output ready_d, valid_e, ctrl_e, rd1_e, rd2_e, imm_ext_e, pc_e,
        output pc_plus4_e, rs1_e, rs2_e, rd_e, bubble_cnt
    );

    modport master (
        output valid_d, instr_d, pc_d, pc_plus4_d, ctrl_d, imm_ext_d,
        output reg_write_w, rd_w, result_w, flush_e, ready_e,
        input  ready_d, valid_e, ctrl_e, rd1_e, rd2_e, imm_ext_e, pc_e,
        input  pc_plus4_e, rs1_e, rs2_e, rd_e, bubble_cnt
    );

endinterface

// File: rtl/decode_stage_pipe_regfile_bypass.sv
// Architectural register file: two read ports, one write port, x0 hardwired
// to zero, and same-cycle write-through so a writeback is visible to decode.
module regfile_bypass #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = mem[ra1];
        if (ra1 == '0)
            rd1 = '0;
        else if (we && wa == ra1)
            rd1 = wd;
    end

    always_comb begin
        rd2 = mem[ra2];
        if (ra2 == '0)
            rd2 = '0;
        else if (we && wa == ra2)
            rd2 = wd;
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage and ID/EX register: register reads, load-use bubble insertion,
// branch flush, execute back-pressure and a saturating bubble counter.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int ALUCTL_W = 3,
    parameter int CNT_W    = 16
) (
    input logic               clk,
    input logic               rst,
    decode_stage_pipe_if.slave bus
);

    localparam int AW = $clog2(NREG);

    // ctrl_t is fixed by the package, so the parameter can only confirm it.
    if (ALUCTL_W != decode_pkg::ALUCTL_W) begin : g_aluctl_check
        $error("ALUCTL_W must match decode_pkg::ALUCTL_W");
    end

    logic [AW-1:0]   rs1_d;
    logic [AW-1:0]   rs2_d;
    logic [AW-1:0]   rd_d;
    logic [XLEN-1:0] rd1_d;
    logic [XLEN-1:0] rd2_d;
    logic            hold;
    logic            hz;
    logic            unused_instr;

    assign rs1_d = bus.instr_d[RS1_LSB +: AW];
    assign rs2_d = bus.instr_d[RS2_LSB +: AW];
    assign rd_d  = bus.instr_d[RD_LSB  +: AW];
    assign unused_instr = ^bus.instr_d;

    regfile_bypass #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1_d),
        .ra2 (rs2_d),
        .rd1 (rd1_d),
        .rd2 (rd2_d),
        .we  (bus.reg_write_w),
        .wa  (bus.rd_w),
        .wd  (bus.result_w)
    );

    assign hold = bus.valid_e & ~bus.ready_e;
    assign hz   = bus.valid_d & bus.valid_e & bus.ctrl_e.result_src
                & (bus.rd_e != '0) & ((bus.rd_e == rs1_d) | (bus.rd_e == rs2_d));

    // Flush outranks back-pressure and hazards: the D slot is always drained.
    assign bus.ready_d = ~rst & (bus.flush_e | ~(hold | hz));

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid_e    <= 1'b0;
            bus.ctrl_e     <= CTRL_NOP;
            bus.rd1_e      <= '0;
            bus.rd2_e      <= '0;
            bus.imm_ext_e  <= '0;
            bus.pc_e       <= '0;
            bus.pc_plus4_e <= '0;
            bus.rs1_e      <= '0;
            bus.rs2_e      <= '0;
            bus.rd_e       <= '0;
            bus.bubble_cnt <= '0;
        end else if (bus.flush_e) begin
            bus.valid_e <= 1'b0;
            bus.ctrl_e  <= CTRL_NOP;
        end else if (!hold) begin
            if (hz) begin
                bus.valid_e <= 1'b0;
                bus.ctrl_e  <= CTRL_NOP;
                if (bus.bubble_cnt != '1)
                    bus.bubble_cnt <= bus.bubble_cnt + CNT_W'(1);
            end else if (bus.valid_d) begin
                bus.valid_e    <= 1'b1;
                bus.ctrl_e     <= bus.ctrl_d;
                bus.rd1_e      <= rd1_d;
                bus.rd2_e      <= rd2_d;
                bus.imm_ext_e  <= bus.imm_ext_d;
                bus.pc_e       <= bus.pc_d;
                bus.pc_plus4_e <= bus.pc_plus4_d;
                bus.rs1_e      <= rs1_d;
                bus.rs2_e      <= rs2_d;
                bus.rd_e       <= rd_d;
            end else begin
                bus.valid_e <= 1'b0;
                bus.ctrl_e  <= CTRL_NOP;
            end
        end
    end

endmodule
